bus_arbiter4: RTL and testbench

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

---
 rtl/bus_arbiter4_pkg.sv | 15 +
 rtl/arb_rr_pick.sv | 22 ++
 rtl/bus_arbiter4.sv | 112 +++++++++++
 tb/tb_bus_arbiter4.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter4_pkg.sv
// Shared types for the 4-way round-robin bus arbiter.
package bus_arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef logic [1:0] idx_t;

    function automatic logic [3:0] idx2onehot(input idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from last+1, wrapping mod 4.
module arb_rr_pick
    import bus_arbiter4_pkg::*;
(
    input  logic [3:0] req,
    input  idx_t       last,
    output idx_t       winner,
    output logic       any_req
);

    always_comb begin
        winner  = last;
        any_req = |req;
        // Scan farthest-first so the nearest requester after 'last' overwrites; k=4 wraps to 'last' itself.
        for (int k = 4; k >= 1; k--) begin
            if (req[idx_t'(last + idx_t'(k))]) begin
                winner = idx_t'(last + idx_t'(k));
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with bounded grant hold and shared data mux.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] DIN0,
    input  logic [WIDTH-1:0] DIN1,
    input  logic [WIDTH-1:0] DIN2,
    input  logic [WIDTH-1:0] DIN3,
    output logic [3:0]       GNT,
    output logic [1:0]       SEL,
    output logic             BUSY,
    output logic [WIDTH-1:0] DOUT
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    idx_t             sel_q, sel_d;
    idx_t             last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    idx_t win;
    logic any_req;
    logic release_grant;

    arb_rr_pick u_pick (
        .req     (REQ),
        .last    (last_q),
        .winner  (win),
        .any_req (any_req)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        last_d        = last_q;
        hold_d        = hold_q;
        release_grant = !REQ[sel_q] || (hold_q == HOLD_LAST);

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = idx2onehot(win);
                    sel_d   = win;
                    last_d  = win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    // Hand over in the same edge; the picker may choose the current owner again.
                    if (any_req) begin
                        gnt_d  = idx2onehot(win);
                        sel_d  = win;
                        last_d = win;
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= 2'd3;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign GNT  = gnt_q;
    assign SEL  = sel_q;
    assign BUSY = (state_q == GRANT);

    always_comb begin
        DOUT = '0;
        if (BUSY) begin
            unique case (sel_q)
                2'd0: DOUT = DIN0;
                2'd1: DOUT = DIN1;
                2'd2: DOUT = DIN2;
                default: DOUT = DIN3;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: two instances (MAX_HOLD 4 and 16) against a cycle-count reference model.
module tb_bus_arbiter4;

    localparam int W        = 8;
    localparam int WAIT_MAX = 3 * 4 + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0;
    logic [W-1:0] din [4];

    logic [3:0]   gnt4, gnt16;
    logic [1:0]   sel4, sel16;
    logic         busy4, busy16;
    logic [W-1:0] dout4, dout16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .CLK(clk), .RST(rst), .REQ(req),
        .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
        .GNT(gnt4), .SEL(sel4), .BUSY(busy4), .DOUT(dout4)
    );

    bus_arbiter4 #(.WIDTH(W), .MAX_HOLD(16)) dut16 (
        .CLK(clk), .RST(rst), .REQ(req),
        .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
        .GNT(gnt16), .SEL(sel16), .BUSY(busy16), .DOUT(dout16)
    );

    // Reference model: tracks how many cycles the current owner has held the bus.
    bit m_busy [2];
    int m_sel  [2];
    int m_last [2];
    int m_held [2];

    function automatic int mh(input int i);
        return (i == 0) ? 4 : 16;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_sel[i]  <= 0;
                m_last[i] <= 3;
                m_held[i] <= 0;
            end else if (!m_busy[i] || !req[m_sel[i]] || m_held[i] == mh(i)) begin
                if (req != 4'b0) begin
                    m_busy[i] <= 1'b1;
                    m_sel[i]  <= rr_pick(req, m_last[i]);
                    m_last[i] <= rr_pick(req, m_last[i]);
                    m_held[i] <= 1;
                end else begin
                    m_busy[i] <= 1'b0;
                    m_held[i] <= 0;
                end
            end else begin
                m_held[i] <= m_held[i] + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt4 !== 4'b0 || sel4 !== 2'b0 || busy4 !== 1'b0 || dout4 !== '0) begin
            errors++;
            $display("FAIL reset4 got gnt=%b sel=%b busy=%b dout=%h want 0000/00/0/00", gnt4, sel4, busy4, dout4);
        end
        checks++;
        if (gnt16 !== 4'b0 || sel16 !== 2'b0 || busy16 !== 1'b0 || dout16 !== '0) begin
            errors++;
            $display("FAIL reset16 got gnt=%b sel=%b busy=%b dout=%h want 0000/00/0/00", gnt16, sel16, busy16, dout16);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0;
    endtask

    task automatic test_first_grant();
        do_reset();
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'hA5; din[3] = 8'h44;
        req = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (gnt4 !== 4'b0100 || sel4 !== 2'b10 || busy4 !== 1'b1 || dout4 !== 8'hA5) begin
            errors++;
            $display("FAIL first_grant4 got gnt=%b sel=%b busy=%b dout=%h want 0100/10/1/a5", gnt4, sel4, busy4, dout4);
        end
        checks++;
        if (gnt16 !== 4'b0100 || sel16 !== 2'b10 || busy16 !== 1'b1 || dout16 !== 8'hA5) begin
            errors++;
            $display("FAIL first_grant16 got gnt=%b sel=%b busy=%b dout=%h want 0100/10/1/a5", gnt16, sel16, busy16, dout16);
        end
    endtask

    task automatic test_release_idle();
        do_reset();
        req = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (gnt16 !== 4'b0001) begin
            errors++;
            $display("FAIL release_setup got gnt=%b want 0001", gnt16);
        end
        @(negedge clk);
        req = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt16 !== 4'b0 || busy16 !== 1'b0 || dout16 !== '0 || sel16 !== 2'b00) begin
                errors++;
                $display("FAIL release_idle cyc=%0d got gnt=%b busy=%b dout=%h sel=%b want 0000/0/00/00", k, gnt16, busy16, dout16, sel16);
            end
        end
    endtask

    task automatic test_rotate();
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt4 !== 4'(1 << ((k / 4) % 4))) begin
                errors++;
                $display("FAIL rotate4 k=%0d got gnt=%b want %b", k, gnt4, 4'(1 << ((k / 4) % 4)));
            end
            checks++;
            if (gnt16 !== 4'(1 << ((k / 16) % 4))) begin
                errors++;
                $display("FAIL rotate16 k=%0d got gnt=%b want %b", k, gnt16, 4'(1 << ((k / 16) % 4)));
            end
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt4 !== 4'b0010 || gnt16 !== 4'b0010 || busy4 !== 1'b1 || busy16 !== 1'b1) begin
                errors++;
                $display("FAIL single_hold k=%0d got gnt4=%b gnt16=%b busy4=%b busy16=%b want 0010 continuous", k, gnt4, gnt16, busy4, busy16);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din[3] = 8'h3C;
        req = 4'b1000;
        @(posedge clk); #1;
        checks++;
        if (gnt16 !== 4'b1000 || dout16 !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_setup got gnt=%b dout=%h want 1000/3c", gnt16, dout16);
        end
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1001;
        @(posedge clk); #1;
        checks++;
        if (gnt16 !== 4'b0 || busy16 !== 1'b0 || dout16 !== '0) begin
            errors++;
            $display("FAIL reset_mid_drop got gnt=%b busy=%b dout=%h want 0000/0/00", gnt16, busy16, dout16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gnt16 !== 4'b0001 || gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_regrant got gnt16=%b gnt4=%b want 0001", gnt16, gnt4);
        end
    endtask

    task automatic test_other_bits();
        do_reset();
        req = 4'b0001;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = {3'($urandom_range(0, 7)), 1'b1};
            @(posedge clk); #1;
            checks++;
            if (gnt4 !== 4'b0001 || gnt16 !== 4'b0001) begin
                errors++;
                $display("FAIL other_bits k=%0d got gnt4=%b gnt16=%b want 0001", k, gnt4, gnt16);
            end
        end
    endtask

    task automatic test_random();
        int           wait_c [4];
        logic [3:0]   eg [2];
        logic [W-1:0] ed [2];
        for (int r = 0; r < 4; r++) wait_c[r] = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            // Requests stay up until dut4 serves them, then may drop.
            for (int r = 0; r < 4; r++) begin
                if (!req[r]) req[r] = ($urandom_range(0, 2) == 0);
                else if (gnt4[r]) req[r] = ($urandom_range(0, 3) != 0);
            end
            for (int r = 0; r < 4; r++) din[r] = W'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                eg[i] = m_busy[i] ? 4'(1 << m_sel[i]) : 4'b0;
                ed[i] = m_busy[i] ? din[m_sel[i]] : '0;
            end
            checks++;
            if (gnt4 !== eg[0] || sel4 !== 2'(m_sel[0]) || busy4 !== m_busy[0] || dout4 !== ed[0]) begin
                errors++;
                $display("FAIL random4 c=%0d got gnt=%b sel=%0d busy=%b dout=%h want %b/%0d/%b/%h",
                         c, gnt4, sel4, busy4, dout4, eg[0], m_sel[0], m_busy[0], ed[0]);
            end
            checks++;
            if (gnt16 !== eg[1] || sel16 !== 2'(m_sel[1]) || busy16 !== m_busy[1] || dout16 !== ed[1]) begin
                errors++;
                $display("FAIL random16 c=%0d got gnt=%b sel=%0d busy=%b dout=%h want %b/%0d/%b/%h",
                         c, gnt16, sel16, busy16, dout16, eg[1], m_sel[1], m_busy[1], ed[1]);
            end
            checks++;
            if (!$onehot0(gnt4) || !$onehot0(gnt16) || (busy4 && gnt4 !== 4'(1 << sel4))) begin
                errors++;
                $display("FAIL onehot c=%0d got gnt4=%b sel4=%0d gnt16=%b want one-hot matching sel", c, gnt4, sel4, gnt16);
            end
            for (int r = 0; r < 4; r++) begin
                if (req[r] && !gnt4[r]) wait_c[r]++;
                else wait_c[r] = 0;
            end
            checks++;
            if (wait_c[0] > WAIT_MAX || wait_c[1] > WAIT_MAX || wait_c[2] > WAIT_MAX || wait_c[3] > WAIT_MAX) begin
                errors++;
                $display("FAIL starvation c=%0d got waits %0d %0d %0d %0d want <= %0d",
                         c, wait_c[0], wait_c[1], wait_c[2], wait_c[3], WAIT_MAX);
                for (int r = 0; r < 4; r++) wait_c[r] = 0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int r = 0; r < 4; r++) din[r] = '0;
        test_reset();
        test_first_grant();
        test_release_idle();
        test_rotate();
        test_single_hold();
        test_reset_mid();
        test_other_bits();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
